// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared register-address width, zero-register constant and operand source select
package operand_fetch_pkg;
  localparam int ADDR_W = $clog2(32);
  localparam int ZERO_REG = 0;
  typedef enum logic [1:0] {SRC_ZERO, SRC_WB, SRC_RF} src_sel_t;
endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// reg_scoreboard: per-register busy bits with one set, two clears and three lookups
module reg_scoreboard #(
  parameter int DEPTH = 32,
  parameter int ADDR = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [ADDR-1:0] set_reg,
  input  logic            clr_en,
  input  logic [ADDR-1:0] clr_reg,
  input  logic            kill_en,
  input  logic [ADDR-1:0] kill_reg,
  input  logic [ADDR-1:0] rs1,
  input  logic [ADDR-1:0] rs2,
  input  logic [ADDR-1:0] rd,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            busy_rd
);
  logic [DEPTH-1:0] busy, set_v, clr_v;
  always_comb begin
    set_v = set_en ? (DEPTH'(1) << set_reg) : '0;
    clr_v = (clr_en ? (DEPTH'(1) << clr_reg) : '0) | (kill_en ? (DEPTH'(1) << kill_reg) : '0);
  end
  always_ff @(posedge clk)
    busy <= reset ? '0 : ((busy & ~clr_v) | set_v) & ~DEPTH'(1);
  assign busy_rs1 = busy[rs1];
  assign busy_rs2 = busy[rs2];
  assign busy_rd  = busy[rd];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: issue stage with writeback forwarding, busy scoreboard and registered output
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int PAYLOAD = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(DEPTH)-1:0]   in_rs1,
  input  logic [$clog2(DEPTH)-1:0]   in_rs2,
  input  logic [$clog2(DEPTH)-1:0]   in_rd,
  input  logic                       in_wen,
  input  logic [PAYLOAD-1:0]         in_payload,
  output logic [$clog2(DEPTH)-1:0]   rreg1,
  output logic [$clog2(DEPTH)-1:0]   rreg2,
  input  logic [WIDTH-1:0]           rdata1,
  input  logic [WIDTH-1:0]           rdata2,
  input  logic                       wb_enable,
  input  logic [$clog2(DEPTH)-1:0]   wb_reg,
  input  logic [WIDTH-1:0]           wb_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_op1,
  output logic [WIDTH-1:0]           out_op2,
  output logic [$clog2(DEPTH)-1:0]   out_rd,
  output logic                       out_wen,
  output logic [PAYLOAD-1:0]         out_payload,
  output logic [31:0]                stall_count
);
  localparam int ADDR = $clog2(DEPTH);
  localparam logic [ADDR-1:0] ZR = ADDR'(ZERO_REG);
  logic b1, b2, bd, f1, f2, fd, hz, accept;
  src_sel_t sel1, sel2;
  logic [WIDTH-1:0] op1, op2;
  reg_scoreboard #(.DEPTH(DEPTH), .ADDR(ADDR)) u_sb (
    .clk(clk),
    .reset(reset),
    .set_en(accept && in_wen && in_rd != ZR),
    .set_reg(in_rd),
    .clr_en(wb_enable),
    .clr_reg(wb_reg),
    .kill_en(flush && out_valid && out_wen),
    .kill_reg(out_rd),
    .rs1(in_rs1),
    .rs2(in_rs2),
    .rd(in_rd),
    .busy_rs1(b1),
    .busy_rs2(b2),
    .busy_rd(bd)
  );
  always_comb begin
    rreg1 = in_rs1;
    rreg2 = in_rs2;
    f1 = wb_enable && wb_reg == in_rs1;
    f2 = wb_enable && wb_reg == in_rs2;
    fd = wb_enable && wb_reg == in_rd;
    hz = (in_rs1 != ZR && b1 && !f1) || (in_rs2 != ZR && b2 && !f2) || (in_wen && in_rd != ZR && bd && !fd);
    in_ready = !reset && !flush && !hz && (!out_valid || out_ready);
    accept = in_valid && in_ready;
    sel1 = in_rs1 == ZR ? SRC_ZERO : f1 ? SRC_WB : SRC_RF;
    sel2 = in_rs2 == ZR ? SRC_ZERO : f2 ? SRC_WB : SRC_RF;
    op1 = sel1 == SRC_ZERO ? '0 : sel1 == SRC_WB ? wb_data : rdata1;
    op2 = sel2 == SRC_ZERO ? '0 : sel2 == SRC_WB ? wb_data : rdata2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op1 <= '0;
      out_op2 <= '0;
      out_rd <= '0;
      out_wen <= 1'b0;
      out_payload <= '0;
      stall_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_op1 <= op1;
        out_op2 <= op2;
        out_rd <= in_rd;
        out_wen <= in_wen;
        out_payload <= in_payload;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && !in_ready && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end
endmodule
